// File: rtl/multi_breath_pwm_if.sv
// Key inputs and LED/status outputs of the multi-channel breathing PWM dimmer.
// The master side drives the debounced keys; the slave side is the dimmer itself.
interface multi_breath_pwm_if #(
  parameter int CH_NUM  = 4,
  parameter int CNT_NUM = 8
);
  localparam int CNT_WIDTH = $clog2(CNT_NUM + 1);
  localparam int SEL_WIDTH = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  logic                        key_up;
  logic                        key_down;
  logic                        key_sel;
  logic                        key_mode;
  logic [CH_NUM-1:0]           led;
  logic [CH_NUM*CNT_WIDTH-1:0] duty_flat;
  logic [SEL_WIDTH-1:0]        sel;
  logic                        mode;
  logic [CNT_WIDTH-1:0]        cnt;

  modport master (
    output key_up,
    output key_down,
    output key_sel,
    output key_mode,
    input  led,
    input  duty_flat,
    input  sel,
    input  mode,
    input  cnt
  );

  modport slave (
    input  key_up,
    input  key_down,
    input  key_sel,
    input  key_mode,
    output led,
    output duty_flat,
    output sel,
    output mode,
    output cnt
  );
endinterface

// File: rtl/multi_breath_pwm.sv
// Multi-channel key-controlled PWM dimmer with a shared period counter and a
// breath mode in which every channel follows one internal triangle duty ramp.
module multi_breath_pwm #(
  parameter int CH_NUM   = 4,
  parameter int CNT_NUM  = 8,
  parameter int STEP_DIV = 2
) (
  input logic              clk,
  input logic              rst,
  multi_breath_pwm_if.slave bus
);
  localparam int CNT_WIDTH  = $clog2(CNT_NUM + 1);
  localparam int SEL_WIDTH  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int PCNT_WIDTH = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = CNT_WIDTH'(CNT_NUM);
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(CNT_NUM - 1);
  localparam logic [CNT_WIDTH-1:0]  DUTY_INIT = CNT_WIDTH'(CNT_NUM / 2);
  localparam logic [SEL_WIDTH-1:0]  SEL_LAST  = SEL_WIDTH'(CH_NUM - 1);
  localparam logic [PCNT_WIDTH-1:0] PCNT_LAST = PCNT_WIDTH'(STEP_DIV - 1);

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_BREATH = 1'b1
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic                  key_up_q;
  logic                  key_down_q;
  logic                  key_sel_q;
  logic                  key_mode_q;
  logic                  press_up;
  logic                  press_down;
  logic                  press_sel;
  logic                  press_mode;

  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CH_NUM-1:0]     led_q;

  mode_t                 mode_q;
  mode_t                 mode_d;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic [SEL_WIDTH-1:0]  sel_d;
  logic [CNT_WIDTH-1:0]  duty_q [CH_NUM];
  logic [CNT_WIDTH-1:0]  duty_d [CH_NUM];
  logic [CNT_WIDTH-1:0]  br_q;
  logic [CNT_WIDTH-1:0]  br_d;
  dir_t                  dir_q;
  dir_t                  dir_d;
  logic [PCNT_WIDTH-1:0] pcnt_q;
  logic [PCNT_WIDTH-1:0] pcnt_d;

  logic [CNT_WIDTH-1:0]        eff [CH_NUM];
  logic [CH_NUM*CNT_WIDTH-1:0] eff_flat;

  // History registers reset to 1 so a key held through reset must be released first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_up_q   <= 1'b1;
      key_down_q <= 1'b1;
      key_sel_q  <= 1'b1;
      key_mode_q <= 1'b1;
    end else begin
      key_up_q   <= bus.key_up;
      key_down_q <= bus.key_down;
      key_sel_q  <= bus.key_sel;
      key_mode_q <= bus.key_mode;
    end
  end

  assign press_up   = bus.key_up   & ~key_up_q;
  assign press_down = bus.key_down & ~key_down_q;
  assign press_sel  = bus.key_sel  & ~key_sel_q;
  assign press_mode = bus.key_mode & ~key_mode_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q <= MODE_MANUAL;
      sel_q  <= '0;
      br_q   <= '0;
      dir_q  <= DIR_UP;
      pcnt_q <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        duty_q[i] <= DUTY_INIT;
      end
    end else begin
      mode_q <= mode_d;
      sel_q  <= sel_d;
      br_q   <= br_d;
      dir_q  <= dir_d;
      pcnt_q <= pcnt_d;
      for (int i = 0; i < CH_NUM; i++) begin
        duty_q[i] <= duty_d[i];
      end
    end
  end

  // Ramp stepping runs first; a mode press entering breath then overrides it with a fresh ramp.
  always_comb begin
    mode_d = mode_q;
    sel_d  = sel_q;
    br_d   = br_q;
    dir_d  = dir_q;
    pcnt_d = pcnt_q;
    for (int i = 0; i < CH_NUM; i++) begin
      duty_d[i] = duty_q[i];
    end

    if (mode_q == MODE_BREATH && cnt_q == CNT_LAST) begin
      if (pcnt_q == PCNT_LAST) begin
        pcnt_d = '0;
        if (dir_q == DIR_UP) begin
          if (br_q == CNT_MAX) begin
            br_d  = CNT_MAX - 1'b1;
            dir_d = DIR_DOWN;
          end else begin
            br_d = br_q + 1'b1;
          end
        end else begin
          if (br_q == '0) begin
            br_d  = CNT_WIDTH'(1);
            dir_d = DIR_UP;
          end else begin
            br_d = br_q - 1'b1;
          end
        end
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end

    if (press_mode) begin
      if (mode_q == MODE_MANUAL) begin
        mode_d = MODE_BREATH;
        br_d   = '0;
        dir_d  = DIR_UP;
        pcnt_d = '0;
      end else begin
        mode_d = MODE_MANUAL;
      end
    end else if (press_sel) begin
      sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
    end else if (mode_q == MODE_MANUAL && (press_up ^ press_down)) begin
      if (press_up && duty_q[sel_q] != CNT_MAX) begin
        duty_d[sel_q] = duty_q[sel_q] + 1'b1;
      end else if (press_down && duty_q[sel_q] != '0) begin
        duty_d[sel_q] = duty_q[sel_q] - 1'b1;
      end
    end
  end

  always_comb begin
    eff_flat = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      eff[i] = (mode_q == MODE_BREATH) ? br_q : duty_q[i];
      eff_flat[i*CNT_WIDTH +: CNT_WIDTH] = eff[i];
    end
  end

  // Active-low drive: lit while the shared counter is below the channel's effective duty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      led_q <= '1;
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        led_q[i] <= (cnt_q < eff[i]) ? 1'b0 : 1'b1;
      end
    end
  end

  assign bus.led       = led_q;
  assign bus.duty_flat = eff_flat;
  assign bus.sel       = sel_q;
  assign bus.mode      = mode_q;
  assign bus.cnt       = cnt_q;
endmodule

// File: tb/tb_multi_breath_pwm.sv
// Directed bench for multi_breath_pwm: key presses with hand-computed duty,
// select, mode, counter and LED expectations.
module tb_multi_breath_pwm;
  localparam int CH_NUM   = 4;
  localparam int CNT_NUM  = 8;
  localparam int STEP_DIV = 2;

  logic clk = 1'b0;
  logic rst;
  int   vec_count  = 0;
  int   miss_count = 0;

  multi_breath_pwm_if #(.CH_NUM(CH_NUM), .CNT_NUM(CNT_NUM)) bus ();

  multi_breath_pwm #(
    .CH_NUM  (CH_NUM),
    .CNT_NUM (CNT_NUM),
    .STEP_DIV(STEP_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    vec_count++;
    if (got !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expected);
    end
  endtask

  // keys = {mode, sel, down, up}; held for one cycle then released for one cycle.
  task automatic applyStimulus(input logic [3:0] keys);
    {bus.key_mode, bus.key_sel, bus.key_down, bus.key_up} = keys;
    @(negedge clk);
    {bus.key_mode, bus.key_sel, bus.key_down, bus.key_up} = 4'b0000;
    @(negedge clk);
  endtask

  task automatic waitCnt(input logic [3:0] target);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 2 * CNT_NUM && !found; i++) begin
      if (bus.cnt == target) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("wait_cnt", {31'd0, found}, 32'd1);
  endtask

  initial begin
    logic [15:0] up_exp [5];
    logic [1:0]  sel_exp [4];
    logic [3:0]  br_tab [18];
    logic [3:0]  br;
    int          lit;

    up_exp  = '{16'h4445, 16'h4446, 16'h4447, 16'h4448, 16'h4448};
    sel_exp = '{2'd1, 2'd2, 2'd3, 2'd0};
    br_tab  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1};

    {bus.key_mode, bus.key_sel, bus.key_down, bus.key_up} = 4'b0000;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cnt",  bus.cnt,       0);
    checkOutput("rst_led",  bus.led,       4'b1111);
    checkOutput("rst_duty", bus.duty_flat, 16'h4444);
    checkOutput("rst_sel",  bus.sel,       0);
    checkOutput("rst_mode", bus.mode,      0);
    rst = 1'b1;

    repeat (2) @(negedge clk);
    lit = 0;
    for (int i = 0; i < 8; i++) begin
      if (!bus.led[0]) lit++;
      @(negedge clk);
    end
    checkOutput("led0_lit_of_8", lit, 4);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b0001);
      checkOutput($sformatf("up%0d", i), bus.duty_flat, up_exp[i]);
    end
    repeat (10) applyStimulus(4'b0010);
    checkOutput("down_to_zero", bus.duty_flat, 16'h4440);
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      if (!bus.led[0]) lit++;
      @(negedge clk);
    end
    checkOutput("led0_never_lit", lit, 0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0100);
      checkOutput($sformatf("sel%0d", i), bus.sel, sel_exp[i]);
    end
    repeat (2) applyStimulus(4'b0100);
    checkOutput("sel_at_2", bus.sel, 2);
    applyStimulus(4'b0001);
    checkOutput("up_ch2", bus.duty_flat, 16'h4540);
    applyStimulus(4'b0011);
    checkOutput("up_down_same", bus.duty_flat, 16'h4540);
    applyStimulus(4'b0101);
    checkOutput("sel_up_sel", bus.sel, 3);
    checkOutput("sel_up_duty", bus.duty_flat, 16'h4540);

    bus.key_up = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("held_rst_duty", bus.duty_flat, 16'h4444);
    checkOutput("held_rst_sel", bus.sel, 0);
    bus.key_up = 1'b0;
    @(negedge clk);
    bus.key_up = 1'b1;
    repeat (100) @(negedge clk);
    bus.key_up = 1'b0;
    @(negedge clk);
    checkOutput("long_press_once", bus.duty_flat, 16'h4445);

    // Enter breath with cnt==3 so every later cnt==0 sample sits at a known ramp phase.
    waitCnt(4'd3);
    applyStimulus(4'b1000);
    checkOutput("breath_mode", bus.mode, 1);
    checkOutput("breath_start", bus.duty_flat, 16'h0000);
    for (int j = 0; j < 35; j++) begin
      waitCnt(4'd0);
      br = br_tab[(j + 1) / 2];
      checkOutput($sformatf("ramp%0d", j), bus.duty_flat, {br, br, br, br});
      @(negedge clk);
    end

    repeat (2) applyStimulus(4'b0001);
    applyStimulus(4'b0010);
    applyStimulus(4'b0100);
    checkOutput("breath_sel", bus.sel, 1);
    applyStimulus(4'b1000);
    checkOutput("manual_mode", bus.mode, 0);
    checkOutput("manual_restore", bus.duty_flat, 16'h4445);

    applyStimulus(4'b1000);
    repeat (20) @(negedge clk);
    checkOutput("mid_breath_mode", bus.mode, 1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_mode", bus.mode, 0);
    checkOutput("mid_rst_duty", bus.duty_flat, 16'h4444);
    checkOutput("mid_rst_cnt", bus.cnt, 0);
    checkOutput("mid_rst_led", bus.led, 4'b1111);
    checkOutput("mid_rst_sel", bus.sel, 0);
    rst = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end
endmodule
